exec_unit: RTL

Execute stage directly downstream of the 16-entry × 16-bit register file. It captures the two read operands (`op1`, `op2`) and an operation code, and computes the result: single-cycle for ADD/SUB/AND/OR, iterative over 16 cycles for unsigned MUL/DIV. It presents the write-back data plus a one-cycle write strobe that drives the register file's `wrData`/`RegWrite`. A `start`/`busy`/`done` handshake lets the controller stall while a multi-cycle operation runs.

---
 rtl/exec_pkg.sv | 11 +
 rtl/seq_muldiv.sv | 58 +++++
 rtl/exec_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: opcodes, FSM state encoding and default word width for the execute stage
package exec_pkg;
    localparam int WIDTH_DEF = 16;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_MUL = 4'd4;
    localparam logic [3:0] OP_DIV = 4'd5;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative unsigned shift-add multiplier / restoring divider, one step per clock
module seq_muldiv
    import exec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             last
);
    logic             run, div_r, src_div;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] b_r, src_hi, src_lo, src_b, nxt_hi, nxt_lo;
    logic [WIDTH:0]   sum, sh, tr;
    assign last = run && cnt == CNT_W'(WIDTH - 1);
    // one iteration; the first one is taken on load straight from the operands (hi=0, lo=a for both ops)
    always_comb begin
        src_div = load ? is_div : div_r;
        src_hi  = load ? '0 : hi;
        src_lo  = load ? a : lo;
        src_b   = load ? b : b_r;
        sum     = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_b} : '0);
        sh      = {src_hi, src_lo[WIDTH-1]};
        tr      = sh - {1'b0, src_b};
        nxt_hi  = src_div ? (tr[WIDTH] ? sh[WIDTH-1:0] : tr[WIDTH-1:0]) : sum[WIDTH:1];
        nxt_lo  = src_div ? {src_lo[WIDTH-2:0], ~tr[WIDTH]} : {sum[0], src_lo[WIDTH-1:1]};
    end
    // accumulator, shift register and iteration counter; stops itself after the last step
    always_ff @(posedge clk) begin
        if (reset) begin
            run   <= 1'b0;
            cnt   <= '0;
            div_r <= 1'b0;
            b_r   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (load) begin
            run   <= 1'b1;
            cnt   <= '0;
            div_r <= is_div;
            b_r   <= b;
            hi    <= nxt_hi;
            lo    <= nxt_lo;
        end else if (run) begin
            run   <= !last;
            cnt   <= cnt + CNT_W'(1);
            hi    <= nxt_hi;
            lo    <= nxt_lo;
        end
    end
endmodule

// File: rtl/exec_unit.sv
// exec_unit: execute stage with single-cycle ALU and iterative MUL/DIV feeding register-file write-back
module exec_unit
    import exec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             reg_write,
    output logic             hi_write,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);
    state_t           state, nstate;
    logic [WIDTH-1:0] sum, dif, alu_res, alu_hi, md_lo, md_hi;
    logic             accept, load, last, div_z, alu_wr, alu_ovf;
    assign busy   = state == S_RUN;
    assign accept = start && !busy;
    assign load   = accept && (alu_op == OP_MUL || (alu_op == OP_DIV && !div_z));
    seq_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .is_div (alu_op == OP_DIV),
        .a      (op1),
        .b      (op2),
        .lo     (md_lo),
        .hi     (md_hi),
        .last   (last)
    );
    // state register
    always_ff @(posedge clk) begin
        state <= reset ? S_IDLE : nstate;
    end
    // next state: DONE falls back to IDLE unless a new start is taken back-to-back
    always_comb begin
        nstate = busy ? (last ? S_DONE : S_RUN) : accept ? (load ? S_RUN : S_DONE) : S_IDLE;
    end
    // single-cycle results, including the divide-by-zero and illegal-op fallbacks
    always_comb begin
        sum     = op1 + op2;
        dif     = op1 - op2;
        div_z   = alu_op == OP_DIV && op2 == '0;
        alu_res = alu_op == OP_ADD ? sum :
                  alu_op == OP_SUB ? dif :
                  alu_op == OP_AND ? (op1 & op2) :
                  alu_op == OP_OR  ? (op1 | op2) :
                  div_z            ? '1 : '0;
        alu_hi  = div_z ? op1 : '0;
        alu_wr  = alu_op <= OP_OR;
        alu_ovf = alu_op == OP_ADD ? (op1[WIDTH-1] == op2[WIDTH-1] && sum[WIDTH-1] != op1[WIDTH-1]) :
                  alu_op == OP_SUB ? (op1[WIDTH-1] != op2[WIDTH-1] && dif[WIDTH-1] != op1[WIDTH-1]) : 1'b0;
    end
    // registered outputs: strobes pulse one cycle, results hold until the next completion
    always_ff @(posedge clk) begin
        if (reset) begin
            result      <= '0;
            result_hi   <= '0;
            reg_write   <= 1'b0;
            hi_write    <= 1'b0;
            done        <= 1'b0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (busy && last) begin
            result      <= md_lo;
            result_hi   <= md_hi;
            reg_write   <= 1'b1;
            hi_write    <= 1'b1;
            done        <= 1'b1;
            zero        <= md_lo == '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (accept && !load) begin
            result      <= alu_res;
            result_hi   <= alu_hi;
            reg_write   <= alu_wr;
            hi_write    <= 1'b0;
            done        <= 1'b1;
            zero        <= alu_op <= OP_DIV && alu_res == '0;
            overflow    <= alu_ovf;
            div_by_zero <= div_z;
        end else begin
            reg_write   <= 1'b0;
            hi_write    <= 1'b0;
            done        <= 1'b0;
        end
    end
endmodule
